// File: rtl/epb_master_ctrl.sv
// EPB initiator: turns single-word user commands into registered EPB bus cycles and waits for rdy.
// Optional WAIT timeout is enabled by defining EPB_MASTER_TIMEOUT_EN.
module epb_master_ctrl #(
  parameter int ADDR_W       = 23,
  parameter int GP_W         = 6,
  parameter int DATA_W       = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
`ifdef EPB_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              epb_clk,
  input  logic              epb_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [GP_W-1:0]   cmd_addr_gp,
  input  logic [1:0]        cmd_be_n,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              epb_cs_n,
  output logic              epb_oe_n,
  output logic              epb_r_w_n,
  output logic [1:0]        epb_be_n,
  output logic [ADDR_W-1:0] epb_addr,
  output logic [GP_W-1:0]   epb_addr_gp,
  output logic [DATA_W-1:0] epb_data_out,
  output logic              epb_data_oe_n,
  input  logic [DATA_W-1:0] epb_data_in,
  input  logic              epb_rdy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
`ifdef EPB_MASTER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(16'hDEAD);
  logic timed_out;
  logic to_flag;
`endif

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef EPB_MASTER_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SETUP;
          cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = S_STROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_STROBE: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        // rdy wins over a timeout that would expire in the same cycle
        if (epb_rdy) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
`ifdef EPB_MASTER_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
          timed_out = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Every bus output is a flop; they change only on state transitions.
  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      epb_cs_n      <= 1'b1;
      epb_oe_n      <= 1'b1;
      epb_r_w_n     <= 1'b1;
      epb_be_n      <= 2'b11;
      epb_addr      <= '0;
      epb_addr_gp   <= '0;
      epb_data_out  <= '0;
      epb_data_oe_n <= 1'b1;
`ifdef EPB_MASTER_TIMEOUT_EN
      to_flag       <= 1'b0;
      rsp_timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      rsp_valid <= 1'b0;
`ifdef EPB_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            epb_cs_n      <= 1'b0;
            epb_addr      <= cmd_addr;
            epb_addr_gp   <= cmd_addr_gp;
            epb_be_n      <= cmd_be_n;
            epb_r_w_n     <= cmd_rnw;
            epb_data_oe_n <= cmd_rnw;
            if (!cmd_rnw) epb_data_out <= cmd_wdata;
          end
        end
        S_SETUP: begin
          if (state_nxt == S_STROBE) epb_oe_n <= ~epb_r_w_n;
        end
        S_WAIT: begin
          if (state_nxt == S_HOLD) begin
            epb_cs_n <= 1'b1;
            epb_oe_n <= 1'b1;
            if (epb_r_w_n) begin
              if (epb_rdy) rsp_rdata <= epb_data_in;
`ifdef EPB_MASTER_TIMEOUT_EN
              else rsp_rdata <= TIMEOUT_DATA;
`endif
            end
`ifdef EPB_MASTER_TIMEOUT_EN
            to_flag <= timed_out;
`endif
          end
        end
        S_HOLD: begin
          if (state_nxt == S_IDLE) begin
            epb_data_oe_n <= 1'b1;
            epb_r_w_n     <= 1'b1;
            epb_be_n      <= 2'b11;
            rsp_valid     <= 1'b1;
`ifdef EPB_MASTER_TIMEOUT_EN
            rsp_timeout   <= to_flag;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef EPB_MASTER_TIMEOUT_EN
  assign rsp_timeout = 1'b0;
`endif

  // The pad buffer must never drive while the responder is enabled onto the bus.
  a_no_contention: assert property (@(posedge epb_clk) disable iff (!epb_rst_n)
    epb_oe_n || epb_data_oe_n);

endmodule

// File: tb/tb_epb_master_ctrl.sv
// Randomized bench for epb_master_ctrl: a responder model plus a transaction-level
// reference that predicts bus phase lengths, latency and response data per command.
module tb_epb_master_ctrl;

  localparam int S  = 1;
  localparam int H  = 1;
  localparam int TO = 10;

  logic        epb_clk = 1'b0;
  logic        epb_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rnw = 1'b0;
  logic [22:0] cmd_addr = '0;
  logic [5:0]  cmd_addr_gp = '0;
  logic [1:0]  cmd_be_n = 2'b11;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n;
  logic [1:0]  epb_be_n;
  logic [22:0] epb_addr;
  logic [5:0]  epb_addr_gp;
  logic [15:0] epb_data_out;
  logic [15:0] epb_data_in = '0;
  logic        epb_rdy = 1'b0;

  epb_master_ctrl #(
    .ADDR_W(23), .GP_W(6), .DATA_W(16), .SETUP_CYCLES(S), .HOLD_CYCLES(H)
`ifdef EPB_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .epb_clk(epb_clk), .epb_rst_n(epb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_addr_gp(cmd_addr_gp), .cmd_be_n(cmd_be_n), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n), .epb_r_w_n(epb_r_w_n), .epb_be_n(epb_be_n),
    .epb_addr(epb_addr), .epb_addr_gp(epb_addr_gp), .epb_data_out(epb_data_out),
    .epb_data_oe_n(epb_data_oe_n), .epb_data_in(epb_data_in), .epb_rdy(epb_rdy)
  );

  always #5 epb_clk = ~epb_clk;

  typedef struct {
    logic        rnw;
    logic [22:0] addr;
    logic [5:0]  gp;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] rd;
    int          d;    // WAIT cycles the responder lets pass before raising rdy
    int          acc;  // cycle index in which the command was accepted
  } txn_t;

  txn_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          c_cs = 0, c_oe = 0, c_doe = 0, c_high = 100;
  logic        prev_cs = 1'b1;
  logic [15:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge epb_clk) cyc <= cyc + 1;

  // Responder and bus monitor, evaluated mid-cycle.
  always @(negedge epb_clk) begin
    txn_t t;
    int   w;
    logic to;
    if (!epb_rst_n) begin
      c_cs = 0; c_oe = 0; c_doe = 0; c_high = 100; prev_cs = 1'b1;
      last_rdata = '0;
      epb_rdy = 1'b0;
    end else begin
      if (!epb_cs_n && prev_cs) begin
        chk("cs_gap", (c_high >= H) ? 32'd1 : 32'd0, 32'd1);
        c_cs = 0; c_oe = 0; c_doe = 0;
      end
      prev_cs = epb_cs_n;
      if (!epb_oe_n) c_oe++;
      if (!epb_data_oe_n) c_doe++;
      chk("no_contention", {31'd0, !epb_oe_n && !epb_data_oe_n}, 32'd0);
      if (!epb_cs_n) begin
        c_cs++;
        c_high = 0;
        chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
        if (q.size() == 0) begin
          chk("cs_without_cmd", 32'd1, 32'd0);
          epb_rdy = 1'b0;
        end else begin
          t = q[0];
          chk("addr", {9'd0, epb_addr}, {9'd0, t.addr});
          chk("addr_gp", {26'd0, epb_addr_gp}, {26'd0, t.gp});
          chk("be_n", {30'd0, epb_be_n}, {30'd0, t.be});
          chk("r_w_n", {31'd0, epb_r_w_n}, {31'd0, t.rnw});
          chk("oe_n", {31'd0, epb_oe_n}, (t.rnw && c_cs >= S + 1) ? 32'd0 : 32'd1);
          chk("data_oe_n", {31'd0, epb_data_oe_n}, {31'd0, t.rnw});
          if (!t.rnw) chk("data_out", {16'd0, epb_data_out}, {16'd0, t.wd});
          epb_rdy = (c_cs >= S + 2 + t.d);
        end
      end else begin
        c_high++;
        epb_rdy = 1'b0;
      end
      epb_data_in = epb_rdy ? q[0].rd : 16'($urandom);
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          t = q.pop_front();
          w = t.d + 1;
          to = 1'b0;
`ifdef EPB_MASTER_TIMEOUT_EN
          if (w > TO) begin w = TO; to = 1'b1; end
`endif
          chk("latency", cyc - t.acc, 1 + S + 1 + w + H);
          chk("cs_low_len", c_cs, S + 1 + w);
          chk("oe_low_len", c_oe, t.rnw ? 1 + w : 0);
          chk("doe_low_len", c_doe, t.rnw ? 0 : S + 1 + w + H);
          chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, to});
          if (t.rnw) last_rdata = to ? 16'hDEAD : t.rd;
          chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, last_rdata});
          chk("idle_be_n", {30'd0, epb_be_n}, 32'd3);
          chk("idle_r_w_n", {31'd0, epb_r_w_n}, 32'd1);
          chk("idle_data_oe_n", {31'd0, epb_data_oe_n}, 32'd1);
          chk("addr_kept", {9'd0, epb_addr}, {9'd0, t.addr});
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_cs_n"}, {31'd0, epb_cs_n}, 32'd1);
    chk({tag, "_oe_n"}, {31'd0, epb_oe_n}, 32'd1);
    chk({tag, "_r_w_n"}, {31'd0, epb_r_w_n}, 32'd1);
    chk({tag, "_data_oe_n"}, {31'd0, epb_data_oe_n}, 32'd1);
    chk({tag, "_be_n"}, {30'd0, epb_be_n}, 32'd3);
    chk({tag, "_addr"}, {9'd0, epb_addr}, 32'd0);
    chk({tag, "_addr_gp"}, {26'd0, epb_addr_gp}, 32'd0);
    chk({tag, "_data_out"}, {16'd0, epb_data_out}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
    chk({tag, "_rsp_rdata"}, {16'd0, rsp_rdata}, 32'd0);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic issue(input txn_t t, input bit keep);
    int n;
    cmd_rnw = t.rnw; cmd_addr = t.addr; cmd_addr_gp = t.gp;
    cmd_be_n = t.be; cmd_wdata = t.wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge epb_clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_wait", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      t.acc = cyc;
      q.push_back(t);
      @(posedge epb_clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
      @(negedge epb_clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge epb_clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  function automatic txn_t mk(input logic rnw, input logic [22:0] a, input logic [1:0] be,
                              input logic [15:0] wd, input logic [15:0] rd, input int d);
    txn_t t;
    t.rnw = rnw; t.addr = a; t.gp = 6'($urandom); t.be = be;
    t.wd = wd; t.rd = rd; t.d = d; t.acc = 0;
    return t;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge epb_clk);
    check_idle("reset");
    #2 epb_rst_n = 1'b1;
    @(negedge epb_clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    issue(mk(1'b0, 23'h001234, 2'b00, 16'hA5C3, 16'h0000, 0), 1'b0);
    wait_idle();
    issue(mk(1'b1, 23'h7FFFFF, 2'b00, 16'h0000, 16'h5A0F, 3), 1'b0);
    wait_idle();
    issue(mk(1'b0, 23'h000010, 2'b10, 16'h1111, 16'h0000, 0), 1'b0);
    wait_idle();
    issue(mk(1'b0, 23'h000020, 2'b01, 16'h2222, 16'h0000, 1), 1'b0);
    wait_idle();

    // Back-to-back writes with cmd_valid held throughout.
    issue(mk(1'b0, 23'h000100, 2'b00, 16'hBEEF, 16'h0000, 0), 1'b1);
    issue(mk(1'b0, 23'h000101, 2'b01, 16'hCAFE, 16'h0000, 0), 1'b1);
    issue(mk(1'b0, 23'h000102, 2'b10, 16'hF00D, 16'h0000, 0), 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(mk(1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a long read WAIT.
    issue(mk(1'b1, 23'h0ABCDE, 2'b00, 16'h0000, 16'h1357, 50), 1'b0);
    n = 0;
    while (c_cs < S + 4 && n < 100) begin
      @(negedge epb_clk);
      n++;
    end
    chk("reached_wait", {31'd0, epb_cs_n}, 32'd0);
    #2 epb_rst_n = 1'b0;
    #1 check_idle("midreset");
    q.delete();
    repeat (2) @(negedge epb_clk);
    #2 epb_rst_n = 1'b1;
    @(negedge epb_clk);
    chk("ready_after_midreset", {31'd0, cmd_ready}, 32'd1);
    issue(mk(1'b1, 23'h0ABCDE, 2'b01, 16'h0000, 16'h2468, 2), 1'b0);
    wait_idle();

    // Responder that stays silent for 1000 WAIT cycles.
    issue(mk(1'b1, 23'h003333, 2'b00, 16'h0000, 16'h7777, 1000), 1'b0);
`ifndef EPB_MASTER_TIMEOUT_EN
    repeat (1000) @(negedge epb_clk);
    chk("still_waiting_cs_n", {31'd0, epb_cs_n}, 32'd0);
    chk("still_waiting_no_rsp", q.size(), 32'd1);
`endif
    wait_idle();
    issue(mk(1'b0, 23'h004444, 2'b00, 16'h9999, 16'h0000, 0), 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
